// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word-addressed data memory behind a multi-cycle
// access FSM, feeding the MEM/WB register and stalling upstream during accesses.
//
//  state | meaning
//  IDLE  | accepting a new op; non-memory and misaligned ops complete in one edge
//  BUSY  | aligned access in flight; cnt counts down to the completing edge
module mem_stage #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] In_Result,
    input  logic [31:0] In_Data,
    input  logic [4:0]  In_Rd,
    input  logic [1:0]  In_MEMControl,
    input  logic [1:0]  In_WBControl,
    output logic [31:0] Out_ReadData,
    output logic [31:0] Out_ALUResult,
    output logic [4:0]  Out_Rd,
    output logic [1:0]  Out_WBControl,
    output logic        Out_AddrError,
    output logic        Out_Stall
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [31:0]         read_data_q;
    logic [31:0]         alu_result_q;
    logic [4:0]          rd_q;
    logic [1:0]          wb_control_q;
    logic                addr_error_q;
    logic [31:0]         mem_q [0:DEPTH-1];

    logic                mem_read;
    logic                mem_write;
    logic                memop;
    logic                aligned;
    logic                access_done;
    logic                mem_we;
    logic [ADDR_W-1:0]   word_idx;
    logic [31:0]         read_data_d;

    assign mem_read  = In_MEMControl[0];
    assign mem_write = In_MEMControl[1];
    assign memop     = mem_read | mem_write;
    assign aligned   = (In_Result[1:0] == 2'b00);
    assign word_idx  = In_Result[ADDR_W+1:2];

    // The edge on which an aligned access finishes, in either state.
    assign access_done = (state_q == IDLE) ? (memop && aligned && (LATENCY == 1))
                                           : (cnt_q == 4'd1);

    assign mem_we      = Rst_n && access_done && mem_write;
    assign read_data_d = (mem_read && !mem_write) ? mem_q[word_idx] : 32'd0;

    assign Out_Stall = (state_q == IDLE) ? (memop && aligned && (LATENCY > 1))
                                         : (cnt_q != 4'd1);

    // Memory is deliberately not reset so contents survive a pipeline flush.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= In_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            rd_q         <= 5'd0;
            wb_control_q <= 2'b00;
            addr_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    alu_result_q <= In_Result;
                    rd_q         <= In_Rd;
                    if (!memop) begin
                        read_data_q  <= 32'd0;
                        wb_control_q <= In_WBControl;
                        addr_error_q <= 1'b0;
                    end else if (!aligned) begin
                        read_data_q  <= 32'd0;
                        wb_control_q <= 2'b00;
                        addr_error_q <= 1'b1;
                    end else if (access_done) begin
                        read_data_q  <= read_data_d;
                        wb_control_q <= In_WBControl;
                        addr_error_q <= 1'b0;
                    end else begin
                        state_q      <= BUSY;
                        cnt_q        <= CNT_INIT;
                        read_data_q  <= 32'd0;
                        wb_control_q <= 2'b00;
                        addr_error_q <= 1'b0;
                    end
                end
                BUSY: begin
                    alu_result_q <= In_Result;
                    rd_q         <= In_Rd;
                    addr_error_q <= 1'b0;
                    if (access_done) begin
                        state_q      <= IDLE;
                        cnt_q        <= 4'd0;
                        read_data_q  <= read_data_d;
                        wb_control_q <= In_WBControl;
                    end else begin
                        cnt_q        <= cnt_q - 4'd1;
                        read_data_q  <= 32'd0;
                        wb_control_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign Out_ReadData  = read_data_q;
    assign Out_ALUResult = alu_result_q;
    assign Out_Rd        = rd_q;
    assign Out_WBControl = wb_control_q;
    assign Out_AddrError = addr_error_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: ops are pushed with model-predicted results
// and a monitor pops/compares whenever an op completes (stall low at an edge).
module tb_mem_stage;

    localparam int LAT = 2;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] In_Result;
    logic [31:0] In_Data;
    logic [4:0]  In_Rd;
    logic [1:0]  In_MEMControl;
    logic [1:0]  In_WBControl;
    logic [31:0] Out_ReadData;
    logic [31:0] Out_ALUResult;
    logic [4:0]  Out_Rd;
    logic [1:0]  Out_WBControl;
    logic        Out_AddrError;
    logic        Out_Stall;

    mem_stage #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .In_Result     (In_Result),
        .In_Data       (In_Data),
        .In_Rd         (In_Rd),
        .In_MEMControl (In_MEMControl),
        .In_WBControl  (In_WBControl),
        .Out_ReadData  (Out_ReadData),
        .Out_ALUResult (Out_ALUResult),
        .Out_Rd        (Out_Rd),
        .Out_WBControl (Out_WBControl),
        .Out_AddrError (Out_AddrError),
        .Out_Stall     (Out_Stall)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [0:255];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic        req_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Reference behaviour: one record per accepted op, memory kept as a plain array.
    function automatic exp_t predict(input logic [31:0] res, input logic [31:0] data,
                                     input logic [4:0] rd, input logic [1:0] memc,
                                     input logic [1:0] wb);
        exp_t e;
        int   idx;
        idx     = int'(res[9:2]);
        e.alu   = res;
        e.rd    = rd;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.wb    = wb;
        e.lat   = 1;
        if (memc != 2'b00) begin
            if (res[1:0] != 2'b00) begin
                e.err = 1'b1;
                e.wb  = 2'b00;
            end else begin
                e.lat = LAT;
                if (memc[1]) model_mem[idx] = data;
                else         e.rdata = model_mem[idx];
            end
        end
        return e;
    endfunction

    task automatic do_op(input logic [31:0] res, input logic [31:0] data,
                         input logic [4:0] rd, input logic [1:0] memc,
                         input logic [1:0] wb);
        int start;
        int k;
        @(negedge Clk);
        In_Result     = res;
        In_Data       = data;
        In_Rd         = rd;
        In_MEMControl = memc;
        In_WBControl  = wb;
        exp_q.push_back(predict(res, data, rd, memc, wb));
        req_valid = 1'b1;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < 20) begin
            @(posedge Clk);
            #2;
            k++;
        end
        req_valid     = 1'b0;
        In_MEMControl = 2'b00;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL op_timeout actual=no_completion required=completion_within_20");
            finish_sim();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, Out_ReadData, 32'd0);
        chk({tag, "_alu"},   Out_ALUResult, 32'd0);
        chk({tag, "_rd"},    32'(Out_Rd), 32'd0);
        chk({tag, "_wb"},    32'(Out_WBControl), 32'd0);
        chk({tag, "_err"},   32'(Out_AddrError), 32'd0);
        chk({tag, "_stall"}, 32'(Out_Stall), 32'd0);
    endtask

    // Monitor: counts edges per op, checks bubbles, pops on completion.
    initial begin
        int   cyc;
        logic v;
        logic s;
        exp_t e;
        cyc = 0;
        forever begin
            @(negedge Clk);
            #2;
            v = req_valid;
            s = Out_Stall;
            @(posedge Clk);
            #1;
            if (v) begin
                cyc++;
                if (!s) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_completion actual=empty_queue required=pending_op");
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency",    32'(cyc), 32'(e.lat));
                        chk("read_data",  Out_ReadData, e.rdata);
                        chk("alu_result", Out_ALUResult, e.alu);
                        chk("rd",         32'(Out_Rd), 32'(e.rd));
                        chk("wb_control", 32'(Out_WBControl), 32'(e.wb));
                        chk("addr_error", 32'(Out_AddrError), 32'(e.err));
                    end
                    cyc = 0;
                    done_cnt++;
                end else begin
                    chk("bubble_wb", 32'(Out_WBControl), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  m;
        Rst_n         = 1'b0;
        In_Result     = $urandom;
        In_Data       = $urandom;
        In_Rd         = 5'($urandom);
        In_MEMControl = 2'b11;
        In_WBControl  = 2'b11;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        In_MEMControl = 2'b00;
        #1;
        chk_all_zero("reset");
        Rst_n = 1'b1;

        for (int i = 0; i < 16; i++) do_op(32'(i * 4), $urandom, 5'($urandom), 2'b10, 2'b00);

        do_op(32'd12, 32'd0, 5'd9, 2'b00, 2'b01);

        do_op(32'd8, 32'hDEADBEEF, 5'd0, 2'b10, 2'b00);
        do_op(32'd8, 32'd0, 5'd5, 2'b01, 2'b11);
        chk("load_deadbeef", Out_ReadData, 32'hDEADBEEF);
        chk("load_wb11", 32'(Out_WBControl), 32'd3);

        do_op(32'd6, 32'd0, 5'd7, 2'b01, 2'b11);
        chk("misaligned_err", 32'(Out_AddrError), 32'd1);

        do_op(32'd16, 32'h11, 5'd0, 2'b10, 2'b00);
        @(negedge Clk);
        In_Result     = 32'd16;
        In_Data       = 32'h55;
        In_MEMControl = 2'b10;
        #1;
        chk("midreset_stall", 32'(Out_Stall), 32'd1);
        Rst_n = 1'b0;
        @(negedge Clk);
        In_MEMControl = 2'b00;
        Rst_n         = 1'b1;
        #1;
        chk_all_zero("midreset");
        do_op(32'd16, 32'd0, 5'd3, 2'b01, 2'b01);
        chk("midreset_keep", Out_ReadData, 32'h11);

        do_op(32'h400, 32'hA5A5A5A5, 5'd0, 2'b10, 2'b00);
        do_op(32'h0, 32'd0, 5'd1, 2'b01, 2'b11);
        chk("addr_wrap", Out_ReadData, 32'hA5A5A5A5);

        for (int i = 0; i < 300; i++) begin
            a = {22'($urandom), 6'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom);
            m = 2'($urandom);
            do_op(a, $urandom, 5'($urandom), m, 2'($urandom));
        end

        repeat (2) @(posedge Clk);
        finish_sim();
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline. It consumes the EX stage outputs: ALU result/address, store data, Rd, MEM and WB control.
- Contains the word-addressed data memory and a multi-cycle access FSM.
- Registers results into the MEM/WB pipeline register for the WB stage.
- Asserts a stall back to upstream stages while a memory access is in progress.

Parameters:
- ADDR_W, 8: word-index width; memory depth is 2**ADDR_W 32-bit words.
- LATENCY, 2: cycles per load/store access; legal values are 1 to 15.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  one clock; reset is synchronous and active-low.
- In_Result  input  32  ALU result from EX; byte address for loads and stores.
- In_Data  input  32  store data from EX.
- In_Rd  input  5  destination register from EX.
- In_MEMControl  input  2  [1] MemWrite, [0] MemRead.
- In_WBControl  input  2  [1] MemToReg, [0] RegWrite.
- Out_ReadData  output  32  registered load data.
- Out_ALUResult  output  32  registered In_Result.
- Out_Rd  output  5  registered Rd.
- Out_WBControl  output  2  registered WB control; 00 marks a bubble.
- Out_AddrError  output  1  registered flag: misaligned memory operation.
- Out_Stall  output  1  combinational; upstream must hold all In_* stable while it is high.

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - FSM goes to IDLE, counter cleared.
  - All registered outputs become 0; Out_Stall=0 in the following cycle.
  - Memory contents are not cleared.
  - Reset overrides everything else, including an access in progress.
- memop = MemRead | MemWrite.
- FSM states: IDLE, BUSY; the counter cnt is 4 bits.
- Non-memory op (In_MEMControl=00), in IDLE:
  - Single cycle, no stall.
  - Next edge: Out_ALUResult=In_Result, Out_Rd=In_Rd, Out_WBControl=In_WBControl, Out_ReadData=0, Out_AddrError=0.
- Misaligned memory op (memop and In_Result[1:0]!=0), in IDLE:
  - Single cycle, no stall, no memory write.
  - Next edge: Out_AddrError=1, Out_WBControl=00, Out_ReadData=0, Out_ALUResult and Out_Rd captured normally.
- Aligned memory op, LATENCY=1: completes at the next edge with no stall (completion actions below).
- Aligned memory op, LATENCY>1:
  - Out_Stall=1 in IDLE.
  - Edge: IDLE -> BUSY, cnt=LATENCY-1, Out_WBControl=00 (bubble).
  - In BUSY, Out_Stall = (cnt!=1).
  - Each BUSY edge with cnt>1: cnt decrements, Out_WBControl=00.
  - Edge with cnt==1: access completes, BUSY -> IDLE.
- Completion actions (single edge):
  - Word index = In_Result[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap.
  - MemWrite=1: mem[index] <= In_Data, written exactly once per access; Out_ReadData=0.
  - MemRead only: Out_ReadData = mem[index], the value before this edge.
  - MemRead and MemWrite both set: treated as a write; read data is 0.
  - Out_ALUResult, Out_Rd, Out_WBControl capture their inputs; Out_AddrError=0.
- Back-to-back: a store completing at edge N is visible to a load accepted at edge N.
- Total latency: an operation accepted in IDLE produces valid outputs LATENCY edges later (1 for non-memory or misaligned ops). Throughput is 1 op per LATENCY cycles for memory ops.
- Reset during BUSY: the pending write is dropped and memory is unchanged.
- The block stores no copy of the request; it relies on upstream holding In_* stable while Out_Stall is high.

Test Plan:
- Reset: hold Rst_n=0 for 2 edges with arbitrary inputs -> all outputs 0, Out_Stall=0, FSM in IDLE.
- Pass-through: In_Result=12, In_Rd=9, In_MEMControl=00, In_WBControl=01 -> next edge Out_ALUResult=12, Out_Rd=9, Out_WBControl=01, Out_ReadData=0, Out_Stall never high.
- Store then load (LATENCY=2):
  - Store: addr 8, data 32'hDEADBEEF, MEM=10, WB=00 -> Out_Stall high 1 cycle, write on the 2nd edge.
  - Load: addr 8, MEM=01, WB=11, Rd=5 -> Out_WBControl=00 after the 1st edge; after the 2nd edge Out_ReadData=32'hDEADBEEF, Out_WBControl=11, Out_Rd=5.
- Misaligned load: addr 6, MEM=01, WB=11 -> no stall; next edge Out_AddrError=1, Out_WBControl=00, Out_ReadData=0.
- Reset mid-access:
  - Store 32'h11 to addr 16 and let it complete.
  - Start a store of 32'h55 to addr 16; assert Rst_n=0 in the stall cycle.
  - Load addr 16 -> 32'h11.
- Address wrap (ADDR_W=8): store 32'hA5A5A5A5 to addr 32'h400, then load addr 0 -> 32'hA5A5A5A5.
